// File: rtl/subleq_core.sv
// SUBLEQ execution controller: fetches an {C,B,A} instruction word, writes mem[B]-mem[A]
// back to B and branches to C when the result is <= 0. Drives both ports of a dual-port RAM.
module subleq_core #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_SIZE  = 110,
  parameter int unsigned RESET_PC  = 10,
  parameter int unsigned HALT_ADDR = 'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic [WORD_SIZE-1:0] add1,
  output logic [WORD_SIZE-1:0] dataIn1,
  output logic                 write1,
  input  logic [WORD_SIZE-1:0] dataOut1,
  output logic [WORD_SIZE-1:0] add2,
  output logic [WORD_SIZE-1:0] dataIn2,
  output logic                 write2,
  input  logic [WORD_SIZE-1:0] dataOut2,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [31:0]          retired
);

  localparam logic [ADDR_W-1:0] MemLimit = ADDR_W'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] ResetPc  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] HaltAddr = ADDR_W'(HALT_ADDR);
  localparam int unsigned       InstrW   = 3 * ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StRead, StExec, StHalt, StFault
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [InstrW-1:0]      instr_q, instr_d;
  logic [31:0]            retired_q, retired_d;

  logic [ADDR_W-1:0]      op_a, op_b, op_c, dec_a, dec_b, pc_next;
  logic [ADDR_W-1:0]      add1_a, add2_a;
  logic [WORD_SIZE-1:0]   diff;
  logic                   le_zero;

  // Datapath: fields of the latched and the incoming instruction, and the difference.
  always_comb begin
    op_a    = instr_q[ADDR_W-1:0];
    op_b    = instr_q[2*ADDR_W-1:ADDR_W];
    op_c    = instr_q[3*ADDR_W-1:2*ADDR_W];
    dec_a   = dataOut1[ADDR_W-1:0];
    dec_b   = dataOut1[2*ADDR_W-1:ADDR_W];
    diff    = dataOut2 - dataOut1;
    le_zero = diff[WORD_SIZE-1] || (diff == '0);
    pc_next = le_zero ? op_c : pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= ResetPc;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = (pc_q < MemLimit) ? StFetch : StFault;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        instr_d = dataOut1[InstrW-1:0];
        state_d = (dec_a >= MemLimit || dec_b >= MemLimit) ? StFault : StRead;
      end
      StRead: state_d = StExec;
      StExec: begin
        if (retired_q != '1) retired_d = retired_q + 32'd1;
        // Halt leaves pc on the halting instruction; otherwise pc advances even into a fault.
        if (op_c == HaltAddr) begin
          state_d = StHalt;
        end else begin
          pc_d = pc_next;
          if (pc_next >= MemLimit) state_d = StFault;
          else if (run)            state_d = StFetch;
          else                     state_d = StIdle;
        end
      end
      StHalt, StFault: state_d = state_q;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    add1_a  = '0;
    add2_a  = '0;
    write2  = 1'b0;
    dataIn2 = '0;
    unique case (state_q)
      StFetch: add1_a = pc_q;
      StRead: begin
        add1_a = op_a;
        add2_a = op_b;
      end
      StExec: begin
        add2_a  = op_b;
        dataIn2 = diff;
        write2  = 1'b1;
      end
      default: ;
    endcase
  end

  assign add1    = {{(WORD_SIZE-ADDR_W){1'b0}}, add1_a};
  assign add2    = {{(WORD_SIZE-ADDR_W){1'b0}}, add2_a};
  assign dataIn1 = '0;
  assign write1  = 1'b0;
  assign pc      = pc_q;
  assign retired = retired_q;
  assign busy    = (state_q == StFetch) || (state_q == StDecode) ||
                   (state_q == StRead)  || (state_q == StExec);
  assign halted  = (state_q == StHalt);
  assign fault   = (state_q == StFault);

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench for subleq_core with a 256-word registered dual-port memory model.
module tb_subleq_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [63:0] add1, dataIn1, dataOut1, add2, dataIn2, dataOut2;
  logic        write1, write2;
  logic [15:0] pc;
  logic        busy, halted, fault;
  logic [31:0] retired;

  logic [63:0] mem [0:255];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  subleq_core dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .add1     (add1),
    .dataIn1  (dataIn1),
    .write1   (write1),
    .dataOut1 (dataOut1),
    .add2     (add2),
    .dataIn2  (dataIn2),
    .write2   (write2),
    .dataOut2 (dataOut2),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  // Registered reads return the pre-write word; writes come only through port 2.
  always @(posedge clk) begin
    dataOut1 <= mem[add1[7:0]];
    dataOut2 <= mem[add2[7:0]];
    if (write2) mem[add2[7:0]] = dataIn2;
  end

  function automatic logic [63:0] ins(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c);
    return {16'h0, c, b, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the write2 pulse of EXEC; a missing pulse is reported as a failed check.
  task automatic wait_exec(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!write2 && n < 16);
    check(tag, write2, 1);
  endtask

  task automatic release_run();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
  endtask

  int n;
  int pulses;

  initial begin
    // Run 1: fall-through, taken branch, branch to halting instruction.
    clear_mem();
    mem[1]  = 64'd1;
    mem[2]  = 64'd2;
    mem[3]  = 64'd3;
    mem[4]  = 64'd2;
    mem[5]  = 64'd0;
    mem[10] = ins(1, 3, 11);
    mem[11] = ins(4, 2, 14);
    mem[14] = ins(5, 5, 12);
    mem[12] = ins(3, 3, 16'hFFFF);
    step();
    check("rst_pc", pc, 10);
    check("rst_retired", retired, 0);
    check("rst_flags", {busy, halted, fault, write2}, 0);
    check("rst_add1", add1, 0);
    check("rst_add2", add2, 0);
    check("rst_din2", dataIn2, 0);
    check("tie_port1", {dataIn1, 63'd0, write1}, 0);

    release_run();
    wait_exec("i1_exec", n);
    check("i1_latency", n, 4);
    check("i1_add2", add2, 3);
    check("i1_din2", dataIn2, 2);
    check("i1_tie_w1", write1, 0);
    step();
    check("i1_pc", pc, 11);
    check("i1_retired", retired, 1);
    check("i1_w2_drop", write2, 0);

    wait_exec("i2_exec", n);
    check("i2_add2", add2, 2);
    check("i2_din2", dataIn2, 0);
    step();
    check("i2_pc", pc, 14);
    check("i2_mem2", mem[2], 0);

    wait_exec("i3_exec", n);
    step();
    check("i3_pc", pc, 12);
    check("i3_mem5", mem[5], 0);

    wait_exec("i4_exec", n);
    check("i4_add2", add2, 3);
    check("i4_din2", dataIn2, 0);
    step();
    check("halt_flag", {halted, fault, busy}, 3'b100);
    check("halt_pc", pc, 12);
    check("halt_mem3", mem[3], 0);
    check("halt_retired", retired, 4);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (write2) pulses++;
    end
    check("halt_no_write", pulses, 0);
    check("halt_pc_frozen", pc, 12);

    // Run 2: B out of range faults in DECODE with no write.
    rst = 1'b1;
    run = 1'b0;
    #1;
    clear_mem();
    mem[1]  = 64'd7;
    mem[10] = ins(1, 200, 11);
    release_run();
    pulses = 0;
    n = 0;
    while (!fault && n < 16) begin
      step();
      n++;
      if (write2) pulses++;
    end
    check("flt_flag", fault, 1);
    check("flt_cycles", n, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      if (write2) pulses++;
    end
    check("flt_no_write", pulses, 0);
    check("flt_retired", retired, 0);
    check("flt_pc", pc, 10);

    // Run 3: drop run during READ, then resume.
    rst = 1'b1;
    run = 1'b0;
    #1;
    clear_mem();
    mem[1]  = 64'd1;
    mem[3]  = 64'd3;
    mem[10] = ins(1, 3, 11);
    mem[11] = ins(1, 3, 11);
    release_run();
    step();
    step();
    step();
    check("rd_add1", add1, 1);
    check("rd_add2", add2, 3);
    run = 1'b0;
    step();
    check("stop_write", {write2, add2[15:0], dataIn2[15:0]}, {1'b1, 16'd3, 16'd2});
    step();
    check("stop_idle", busy, 0);
    check("stop_pc", pc, 11);
    step();
    step();
    check("stop_hold", {busy, add1[15:0], write2}, 0);
    run = 1'b1;
    step();
    check("resume_add1", add1, 11);

    // Run 4: asynchronous reset in the middle of EXEC.
    wait_exec("ar_exec", n);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_write2", write2, 0);
    check("ar_pc", pc, 10);
    check("ar_retired", retired, 0);
    check("ar_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("ar_first_add1", add1, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/subleq_core.md
Name: subleq_core

Overview:
- Single-instruction (SUBLEQ) execution controller that drives both ports of the dual-port word memory directly upstream of it.
- Fetches a packed instruction word and reads operands A and B.
- Writes mem[B] − mem[A] back to B, then branches to C if the result is ≤ 0, otherwise falls through to PC+1.
- Sits between the top-level run control and the memory; the memory holds both program and data.

Parameters:
- WORD_SIZE, 64, memory word width (matches gc::WORD_SIZE).
- ADDR_W, 16, width of each address field and of pc.
- MEM_SIZE, 110, number of valid words; any address ≥ MEM_SIZE faults.
- RESET_PC, 10, pc value after reset.
- HALT_ADDR, 16'hFFFF, C-field value that halts the core after the instruction completes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- add1  out  WORD_SIZE  memory port-1 address (fetch and operand A), zero-extended from ADDR_W.
- dataIn1  out  WORD_SIZE  memory port-1 write data; constant 0.
- write1  out  1  memory port-1 write enable; constant 0.
- dataOut1  in  WORD_SIZE  memory port-1 read data, registered, valid the cycle after the address.
- add2  out  WORD_SIZE  memory port-2 address (operand B and writeback).
- dataIn2  out  WORD_SIZE  memory port-2 write data (difference).
- write2  out  1  memory port-2 write enable.
- dataOut2  in  WORD_SIZE  memory port-2 read data, registered, 1-cycle latency.
- pc  out  ADDR_W  current instruction address.
- busy  out  1  high in FETCH/DECODE/READ/EXEC.
- halted  out  1  sticky; HALT state reached.
- fault  out  1  sticky; FAULT state reached.
- retired  out  32  count of completed instructions, saturating at 2^32−1.

Behaviour:
- Instruction format: A = word[15:0], B = word[31:16], C = word[47:32]; bits [63:48] are ignored.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, pc = RESET_PC, instr register = 0, retired = 0, halted = fault = 0.
  - write2 = 0, add1 = add2 = dataIn2 = 0.
- Memory outputs are Moore-decoded from state, pc and the instr register, except dataIn2, which is combinational from dataOut1/dataOut2 in EXEC.
- IDLE: all write enables 0. If run = 1 and pc < MEM_SIZE, go to FETCH. If run = 1 and pc ≥ MEM_SIZE, go to FAULT.
- FETCH: add1 = pc. Go to DECODE.
- DECODE:
  - Latch instr = dataOut1.
  - If A ≥ MEM_SIZE or B ≥ MEM_SIZE (checked on dataOut1 fields), go to FAULT. Otherwise go to READ.
- READ: add1 = A, add2 = B. Go to EXEC.
- EXEC:
  - diff = dataOut2 − dataOut1, modulo 2^WORD_SIZE; signed two's-complement compare.
  - add2 = B, dataIn2 = diff, write2 = 1 for exactly this one cycle.
  - retired increments.
  - Next pc = C if diff ≤ 0 (signed), else pc+1.
  - Next state, in priority order:
    - HALT if C == HALT_ADDR, regardless of branch outcome; pc is left unchanged.
    - FAULT if the next pc ≥ MEM_SIZE; pc is still updated and the write still occurs.
    - FETCH if run = 1.
    - IDLE if run = 0.
- Latency: 4 cycles per instruction; one write per instruction.
- A == B is legal: both ports read the same word, diff = 0, the branch is taken, and B is written with 0.
- Self-modifying code is legal: a write to an instruction word is visible at the next FETCH, because the write completes before FETCH samples memory.
- run deasserted mid-instruction: the current instruction completes, then the core enters IDLE with pc = next pc. Reasserting run resumes from that pc.
- HALT and FAULT are terminal. Only rst exits them. write2 = 0 and pc is frozen in both.
- The write-back never uses port 1; write1 and dataIn1 are tied to 0 at all times.

Test Plan:
- Preload mem[1] = 1, mem[3] = 3, and mem[10] with A = 1, B = 3, C = 11; run = 1 after reset.
  -> EXEC occurs in cycle 4 with write2 = 1, add2 = 3, dataIn2 = 2; pc becomes 11 (fall-through); retired = 1.
- Preload mem[2] = 2, mem[4] = 2, and mem[11] with A = 4, B = 2, C = 14.
  -> mem[2] becomes 0, the branch is taken, pc = 14.
- Preload mem[12] with A = 3, B = 3, C = 0xFFFF.
  -> mem[3] becomes 0, halted = 1, pc stays 12, and write2 remains 0 for 20 further cycles with run = 1.
- Instruction with B = 200 (≥ MEM_SIZE).
  -> fault = 1 after DECODE, no write2 pulse, retired unchanged.
- Drop run during READ of the instruction at pc 10.
  -> the write still occurs, the core is in IDLE with pc = 11; reasserting run fetches address 11.
- Assert rst asynchronously during EXEC (between clock edges).
  -> write2 drops immediately, pc = 10, retired = 0, state = IDLE.
  -> After release with run = 1, the first add1 = 10.
